// File: rtl/ddr_maint_responder.sv
// Maintenance-handshake responder: gates host R/W traffic, drains in-flight bursts and
// sequences PREA/REF/MRS on the command bus. Define DDR_MAINT_STATS_EN to build refresh_cnt.
module ddr_maint_responder #(
  parameter int MRS_WIDTH       = 14,
  parameter int NUM_BANKS       = 16,
  parameter int MAX_OUTSTANDING = 15,
  parameter int T_RP            = 11,
  parameter int T_RFC           = 208,
  parameter int T_MOD           = 24
) (
  input  logic                 clock_t,
  input  logic                 reset_n,
  input  logic                 rw_proc,
  input  logic                 refresh_rdy,
  input  logic                 mrs_update_rdy,
  input  logic [MRS_WIDTH-1:0] mrs_update_cmd,
  input  logic                 rw_req_valid,
  output logic                 rw_req_ready,
  input  logic                 rw_issue,
  input  logic                 rw_done,
  input  logic [NUM_BANKS-1:0] bank_open,
  output logic                 rw_idle,
  output logic                 cmd_valid,
  output logic [1:0]           cmd_type,
  output logic [MRS_WIDTH-1:0] cmd_addr,
  output logic [1:0]           cmd_ba,
  output logic                 cnt_err,
  output logic [15:0]          refresh_cnt
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  // Wait states leave on a count of 1, so loading N-1 puts the next command N cycles out.
  localparam logic [7:0] RP_LOAD  = 8'(T_RP - 1);
  localparam logic [7:0] RFC_LOAD = 8'(T_RFC - 1);
  localparam logic [7:0] MOD_LOAD = 8'(T_MOD - 1);

  if (T_RP > 255 || T_RFC > 255 || T_MOD > 255 || T_RP < 2 || T_RFC < 2 || T_MOD < 2)
  begin : g_bad_timing
    $error("ddr_maint_responder: T_RP/T_RFC/T_MOD must lie in 2..255");
  end

  typedef enum logic [3:0] {
    M_RUN, M_DRAIN, M_QUIET, M_PREA, M_TRP, M_REF, M_TRFC, M_MRS, M_TMOD
  } state_t;

  typedef enum logic [1:0] {CMD_NOP, CMD_PREA, CMD_REF, CMD_MRS} cmd_t;

  state_t                 state, next_state;
  logic [OW-1:0]          outstanding;
  logic                   ref_pend, mrs_pend;
  logic                   ref_clr, mrs_clr;
  logic [MRS_WIDTH-1:0]   mrs_cmd;
  logic [7:0]             wait_cnt;
  logic                   wait_load;
  logic [7:0]             load_val;

  // Host request handshake does not depend on valid; it is carried only for interface completeness.
  logic unused_req_valid;
  assign unused_req_valid = rw_req_valid;

  assign rw_req_ready = (state == M_RUN) && rw_proc && (outstanding < MAX_OUT);
  assign cmd_ba       = 2'b00;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    wait_load  = 1'b0;
    load_val   = '0;
    ref_clr    = 1'b0;
    mrs_clr    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_type   = CMD_NOP;
    cmd_addr   = '0;
    case (state)
      M_RUN:   if (!rw_proc) next_state = M_DRAIN;
      M_DRAIN: if (outstanding == '0) next_state = M_QUIET;
      M_QUIET: begin
        if (ref_pend || mrs_pend) begin
          if (|bank_open)    next_state = M_PREA;
          else if (ref_pend) next_state = M_REF;
          else               next_state = M_MRS;
        end else if (rw_proc) begin
          next_state = M_RUN;
        end
      end
      M_PREA: begin
        cmd_valid  = 1'b1;
        cmd_type   = CMD_PREA;
        wait_load  = 1'b1;
        load_val   = RP_LOAD;
        next_state = M_TRP;
      end
      M_TRP:   if (wait_cnt <= 8'd1) next_state = ref_pend ? M_REF : M_MRS;
      M_REF: begin
        cmd_valid  = 1'b1;
        cmd_type   = CMD_REF;
        ref_clr    = 1'b1;
        wait_load  = 1'b1;
        load_val   = RFC_LOAD;
        next_state = M_TRFC;
      end
      M_TRFC:  if (wait_cnt <= 8'd1) next_state = M_QUIET;
      M_MRS: begin
        cmd_valid  = 1'b1;
        cmd_type   = CMD_MRS;
        cmd_addr   = mrs_cmd;
        mrs_clr    = 1'b1;
        wait_load  = 1'b1;
        load_val   = MOD_LOAD;
        next_state = M_TMOD;
      end
      M_TMOD:  if (wait_cnt <= 8'd1) next_state = M_QUIET;
      default: next_state = M_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      state    <= M_RUN;
      rw_idle  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      rw_idle  <= !(next_state inside {M_RUN, M_DRAIN});
      if (wait_load)            wait_cnt <= load_val;
      else if (wait_cnt != '0)  wait_cnt <= wait_cnt - 8'd1;
    end
  end

  // Saturating in-flight counter; any illegal step latches cnt_err until reset.
  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      outstanding <= '0;
      cnt_err     <= 1'b0;
    end else begin
      case ({rw_issue, rw_done})
        2'b10: if (outstanding == MAX_OUT) cnt_err <= 1'b1;
               else outstanding <= outstanding + 1'b1;
        2'b01: if (outstanding == '0) cnt_err <= 1'b1;
               else outstanding <= outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the payload register is reset too, so cmd_addr can never expose a stale value after reset.
  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      ref_pend <= 1'b0;
      mrs_pend <= 1'b0;
      mrs_cmd  <= '0;
    end else begin
      // Clearing wins: a pulse landing on the command cycle is still the request being served.
      if (ref_clr)          ref_pend <= 1'b0;
      else if (refresh_rdy) ref_pend <= 1'b1;
      if (mrs_clr)             mrs_pend <= 1'b0;
      else if (mrs_update_rdy) mrs_pend <= 1'b1;
      if (mrs_update_rdy) mrs_cmd <= mrs_update_cmd;
    end
  end

`ifdef DDR_MAINT_STATS_EN
  always_ff @(posedge clock_t) begin
    if (!reset_n)            refresh_cnt <= '0;
    else if (state == M_REF) refresh_cnt <= refresh_cnt + 16'd1;
  end
`else
  assign refresh_cnt = '0;
`endif

endmodule
